// File: rtl/vvu_requant_pkg.sv
// Shared helpers for the VVU requantization stage: byte-align width and range clamp.
package vvu_requant_pkg;

    localparam int unsigned WIDE_W = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int unsigned ba(input int unsigned w);
        return (w + 7) / 8 * 8;
    endfunction

    // Saturate v to a w-bit signed or unsigned range.
    function automatic wide_t clamp(input wide_t v, input int unsigned w, input bit sgn);
        wide_t hi;
        wide_t lo;
        if (sgn) begin
            hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
            lo = -(wide_t'(1) <<< (w - 1));
        end else begin
            hi = (wide_t'(1) <<< w) - wide_t'(1);
            lo = '0;
        end
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/vvu_requant_lane.sv
// Per-lane shift and saturate; VVU_REQUANT_ROUND_EN adds round-half-up before the shift.
module vvu_requant_lane
    import vvu_requant_pkg::*;
#(
    parameter int unsigned SUM_W      = 21,
    parameter int unsigned SHIFT      = 4,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter bit          SIGNED_OUT = 1'b1
) (
    input  logic signed [SUM_W-1:0]     sum,
    output logic        [OUT_WIDTH-1:0] q_c
);

`ifdef VVU_REQUANT_ROUND_EN
    localparam int unsigned RW = SUM_W + 1;
    localparam logic signed [RW-1:0] RND = RW'((64'd1 << SHIFT) >> 1);

    logic signed [RW-1:0] rnd_c;
    logic signed [RW-1:0] shr_c;

    always_comb begin
        rnd_c = RW'(sum) + RND;
        shr_c = rnd_c >>> SHIFT;
        q_c   = OUT_WIDTH'(clamp(WIDE_W'(shr_c), OUT_WIDTH, SIGNED_OUT));
    end
`else
    logic signed [SUM_W-1:0] shr_c;

    always_comb begin
        shr_c = sum >>> SHIFT;
        q_c   = OUT_WIDTH'(clamp(WIDE_W'(shr_c), OUT_WIDTH, SIGNED_OUT));
    end
`endif

endmodule

// File: rtl/vvu_requant_axi.sv
// Bias-add, shift and saturate stage joining accumulator and bias AXI streams.
// Optional rounding before the shift is enabled by defining VVU_REQUANT_ROUND_EN.
module vvu_requant_axi
    import vvu_requant_pkg::*;
#(
    parameter int unsigned PE         = 4,
    parameter int unsigned ACCU_WIDTH = 20,
    parameter int unsigned BIAS_WIDTH = 20,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned SHIFT      = 4,
    parameter bit          SIGNED_OUT = 1'b1,
    parameter int unsigned NF         = 128
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [ba(PE*ACCU_WIDTH)-1:0]     s_axis_input_tdata,
    input  logic                             s_axis_input_tvalid,
    output logic                             s_axis_input_tready,
    input  logic [ba(PE*BIAS_WIDTH)-1:0]     s_axis_bias_tdata,
    input  logic                             s_axis_bias_tvalid,
    output logic                             s_axis_bias_tready,
    output logic [ba(PE*OUT_WIDTH)-1:0]      m_axis_output_tdata,
    output logic                             m_axis_output_tvalid,
    input  logic                             m_axis_output_tready,
    output logic                             m_axis_output_tlast
);

    localparam int unsigned SUM_W = ACCU_WIDTH + 1;
    localparam int unsigned OB_W  = ba(PE * OUT_WIDTH);
    localparam int unsigned CNT_W = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NF - 1);

    typedef logic [PE-1:0][SUM_W-1:0]     sum_vec_t;
    typedef logic [PE-1:0][OUT_WIDTH-1:0] out_vec_t;

    logic             a_vld_q, a_vld_d;
    sum_vec_t         a_sum_q, a_sum_d;
    logic             a_last_q, a_last_d;
    logic             b_vld_q, b_vld_d;
    logic [OB_W-1:0]  b_data_q, b_data_d;
    logic             b_last_q, b_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic     b_adv_c;
    logic     a_adv_c;
    logic     accept_c;
    out_vec_t lane_q_c;

    for (genvar k = 0; k < PE; k++) begin : g_lane
        vvu_requant_lane #(
            .SUM_W     (SUM_W),
            .SHIFT     (SHIFT),
            .OUT_WIDTH (OUT_WIDTH),
            .SIGNED_OUT(SIGNED_OUT)
        ) u_lane (
            .sum(a_sum_q[k]),
            .q_c(lane_q_c[k])
        );
    end

    // Join, elastic advance and frame counting.
    always_comb begin
        b_adv_c  = !b_vld_q || m_axis_output_tready;
        a_adv_c  = !a_vld_q || b_adv_c;
        accept_c = a_adv_c && s_axis_input_tvalid && s_axis_bias_tvalid && !ap_rst;

        a_vld_d  = a_vld_q;
        a_sum_d  = a_sum_q;
        a_last_d = a_last_q;
        b_vld_d  = b_vld_q;
        b_data_d = b_data_q;
        b_last_d = b_last_q;
        cnt_d    = cnt_q;

        if (a_adv_c) begin
            a_vld_d = accept_c;
        end
        if (accept_c) begin
            for (int unsigned k = 0; k < PE; k++) begin
                a_sum_d[k] = SUM_W'(signed'(s_axis_input_tdata[k*ACCU_WIDTH +: ACCU_WIDTH]))
                           + SUM_W'(signed'(s_axis_bias_tdata[k*BIAS_WIDTH +: BIAS_WIDTH]));
            end
            a_last_d = (cnt_q == CNT_LAST);
            cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        // Stage B reloads straight from A on a handoff, so no bubble is inserted.
        if (b_adv_c) begin
            b_vld_d = a_vld_q;
            if (a_vld_q) begin
                b_data_d                  = '0;
                b_data_d[PE*OUT_WIDTH-1:0] = lane_q_c;
                b_last_d                  = a_last_q;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            a_vld_q  <= 1'b0;
            a_sum_q  <= '0;
            a_last_q <= 1'b0;
            b_vld_q  <= 1'b0;
            b_data_q <= '0;
            b_last_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_vld_q  <= a_vld_d;
            a_sum_q  <= a_sum_d;
            a_last_q <= a_last_d;
            b_vld_q  <= b_vld_d;
            b_data_q <= b_data_d;
            b_last_q <= b_last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign s_axis_input_tready  = a_adv_c && s_axis_bias_tvalid && !ap_rst;
    assign s_axis_bias_tready   = a_adv_c && s_axis_input_tvalid && !ap_rst;
    assign m_axis_output_tdata  = b_data_q;
    assign m_axis_output_tvalid = b_vld_q;
    assign m_axis_output_tlast  = b_last_q;

endmodule

// File: tb/tb_vvu_requant_axi.sv
// Bench for vvu_requant_axi: signed and unsigned instances share stimulus, checked against an arithmetic model.
module tb_vvu_requant_axi;

    localparam int NFV = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [79:0] in_data;
    logic [79:0] bias_data;
    logic        in_v, b_v, in_r, b_r, in_r1, b_r1;
    logic [31:0] o0, o1;
    logic        ov0, ov1, ol0, ol1, m_r;

    always #5 clk = ~clk;

    vvu_requant_axi #(
        .PE(4), .ACCU_WIDTH(20), .BIAS_WIDTH(20), .OUT_WIDTH(8),
        .SHIFT(4), .SIGNED_OUT(1'b1), .NF(128)
    ) u_dut_s (
        .ap_clk(clk), .ap_rst(rst),
        .s_axis_input_tdata(in_data), .s_axis_input_tvalid(in_v), .s_axis_input_tready(in_r),
        .s_axis_bias_tdata(bias_data), .s_axis_bias_tvalid(b_v), .s_axis_bias_tready(b_r),
        .m_axis_output_tdata(o0), .m_axis_output_tvalid(ov0),
        .m_axis_output_tready(m_r), .m_axis_output_tlast(ol0)
    );

    vvu_requant_axi #(
        .PE(4), .ACCU_WIDTH(20), .BIAS_WIDTH(20), .OUT_WIDTH(8),
        .SHIFT(4), .SIGNED_OUT(1'b0), .NF(128)
    ) u_dut_u (
        .ap_clk(clk), .ap_rst(rst),
        .s_axis_input_tdata(in_data), .s_axis_input_tvalid(in_v), .s_axis_input_tready(in_r1),
        .s_axis_bias_tdata(bias_data), .s_axis_bias_tvalid(b_v), .s_axis_bias_tready(b_r1),
        .m_axis_output_tdata(o1), .m_axis_output_tvalid(ov1),
        .m_axis_output_tready(m_r), .m_axis_output_tlast(ol1)
    );

    typedef struct {
        int accu[4];
        int bias[4];
        int idx;
    } beat_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        l0;
        logic        l1;
    } obs_t;

    beat_t acc_q[$];
    obs_t  out_q[$];
    beat_t mon_b;
    obs_t  mon_o;
    int    beat_idx = 0;
    int    acc_count = 0;
    int    passed = 0;
    int    total = 0;
    bit    xfer = 1'b0;
    bit    prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic        prev_l;

    // Model: add, floor-divide by 16 (optionally after +8), then clamp.
    function automatic int lane_ref(input int a, input int b, input bit sgn);
        int s;
        int q;
        s = a + b;
`ifdef VVU_REQUANT_ROUND_EN
        s = s + 8;
`endif
        if (s >= 0) q = s / 16;
        else        q = -((-s + 15) / 16);
        if (sgn) begin
            if (q > 127)  q = 127;
            if (q < -128) q = -128;
        end else begin
            if (q > 255) q = 255;
            if (q < 0)   q = 0;
        end
        return q;
    endfunction

    function automatic logic [31:0] ref_bus(input beat_t b, input bit sgn);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = 8'(lane_ref(b.accu[k], b.bias[k], sgn));
        return r;
    endfunction

    function automatic int rand_val();
        logic [19:0] r;
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 8000)) - 4000;
        r = 20'($urandom);
        return int'($signed(r));
    endfunction

    // Observe both handshakes at the falling edge, ahead of the edge that commits them.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            xfer = 1'b0;
        end else begin
            total++;
            if ((in_v && in_r) !== (b_v && b_r)) begin
                $display("FAIL join: input_xfer=%0b bias_xfer=%0b, required equal", in_v && in_r, b_v && b_r);
            end else passed++;
            if (prev_stall) begin
                total++;
                if (ov0 !== 1'b1 || o0 !== prev_d || ol0 !== prev_l) begin
                    $display("FAIL hold_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             ov0, o0, ol0, prev_d, prev_l);
                end else passed++;
            end
            xfer = in_v && in_r && b_v && b_r;
            if (xfer) begin
                for (int k = 0; k < 4; k++) begin
                    mon_b.accu[k] = int'($signed(in_data[k*20 +: 20]));
                    mon_b.bias[k] = int'($signed(bias_data[k*20 +: 20]));
                end
                mon_b.idx = beat_idx;
                beat_idx++;
                acc_count++;
                acc_q.push_back(mon_b);
            end
            if (ov0 && m_r) begin
                mon_o.d0 = o0;
                mon_o.d1 = o1;
                mon_o.l0 = ol0;
                mon_o.l1 = ol1;
                out_q.push_back(mon_o);
            end
            prev_stall = ov0 && !m_r;
            prev_d = o0;
            prev_l = ol0;
        end
    end

    task automatic push(input int a[4], input int b[4]);
        int n;
        for (int k = 0; k < 4; k++) begin
            in_data[k*20 +: 20]   = 20'(a[k]);
            bias_data[k*20 +: 20] = 20'(b[k]);
        end
        in_v = 1'b1;
        b_v  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(in_r && b_r) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL push_timeout: no handshake after %0d cycles, required acceptance", n);
        end
        @(posedge clk); #1;
        in_v = 1'b0;
        b_v  = 1'b0;
    endtask

    task automatic push_rand();
        int va[4];
        int vb[4];
        for (int k = 0; k < 4; k++) begin
            va[k] = rand_val();
            vb[k] = rand_val();
        end
        push(va, vb);
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_r = 1'b1;
        while ((out_q.size() < acc_q.size() || ov0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            total++;
            $display("FAIL drain_timeout: outputs=%0d after %0d cycles, required %0d", out_q.size(), n, acc_q.size());
        end
    endtask

    task automatic test_reset();
        in_data = '0;
        bias_data = '0;
        in_v = 1'b1;
        b_v = 1'b1;
        m_r = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ov0 !== 1'b0 || ol0 !== 1'b0 || o0 !== 32'h0 || ov1 !== 1'b0) begin
            $display("FAIL reset_outputs: valid=%b last=%b data=%h uvalid=%b, required 0/0/0/0", ov0, ol0, o0, ov1);
        end else passed++;
        total++;
        if (in_r !== 1'b0 || b_r !== 1'b0) begin
            $display("FAIL reset_treadys: input=%b bias=%b, required 0/0", in_r, b_r);
        end else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        in_v = 1'b0;
        @(negedge clk);
        total++;
        if (in_r !== 1'b1 || b_r !== 1'b0) begin
            $display("FAIL ready_join_rule: input=%b bias=%b, required 1/0", in_r, b_r);
        end else passed++;
        @(posedge clk); #1;
        b_v = 1'b0;
    endtask

    task automatic test_basic();
        int va[4];
        int vb[4];
        beat_t mb;
        obs_t mo;
        logic [31:0] e0, e1;
        logic el;
        va = '{100, -100, 0, 2047};
        vb = '{12, -12, 5, 0};
        m_r = 1'b1;
        push(va, vb);
        @(negedge clk);
        total++;
        if (ov0 !== 1'b0) $display("FAIL basic_latency_early: valid=%b one cycle after accept, required 0", ov0);
        else passed++;
        @(negedge clk);
        total++;
        if (ov0 !== 1'b1 || o0 !== 32'h7F00F907) begin
            $display("FAIL basic_signed: valid=%b data=%h, required valid=1 data=7f00f907", ov0, o0);
        end else passed++;
        total++;
        if (o1 !== 32'h7F000007) $display("FAIL basic_unsigned: data=%h, required 7f000007", o1);
        else passed++;
        @(posedge clk); #1;
        drain();
        total++;
        if (out_q.size() !== acc_q.size()) $display("FAIL basic_count: outputs=%0d required %0d", out_q.size(), acc_q.size());
        else passed++;
        while (acc_q.size() > 0 && out_q.size() > 0) begin
            mb = acc_q.pop_front();
            mo = out_q.pop_front();
            e0 = ref_bus(mb, 1'b1);
            e1 = ref_bus(mb, 1'b0);
            el = (mb.idx % NFV) == NFV - 1;
            total++;
            if (mo.d0 !== e0 || mo.d1 !== e1 || mo.l0 !== el || mo.l1 !== el) begin
                $display("FAIL basic_beat%0d: s=%h u=%h last=%b/%b, required s=%h u=%h last=%b",
                         mb.idx, mo.d0, mo.d1, mo.l0, mo.l1, e0, e1, el);
            end else passed++;
        end
        acc_q.delete();
        out_q.delete();
    endtask

    task automatic test_saturation();
        int va[4];
        int vb[4];
        beat_t mb;
        obs_t mo;
        logic [31:0] e0, e1, sc;
        logic el;
`ifdef VVU_REQUANT_ROUND_EN
        sc = 32'h7FFD7FFD;
`else
        sc = 32'h7FFC7FFC;
`endif
        m_r = 1'b1;
        va = '{524287, 524287, 524287, 524287};
        push(va, va);
        va = '{-524288, -524288, -524288, -524288};
        push(va, va);
        va = '{-50, 8000, -50, 8000};
        vb = '{0, 0, 0, 0};
        push(va, vb);
        drain();
        total++;
        if (out_q.size() !== 3) $display("FAIL sat_count: outputs=%0d required 3", out_q.size());
        else passed++;
        if (out_q.size() >= 3) begin
            total++;
            if (out_q[0].d0 !== 32'h7F7F7F7F || out_q[0].d1 !== 32'hFFFFFFFF)
                $display("FAIL sat_high: s=%h u=%h, required 7f7f7f7f/ffffffff", out_q[0].d0, out_q[0].d1);
            else passed++;
            total++;
            if (out_q[1].d0 !== 32'h80808080 || out_q[1].d1 !== 32'h00000000)
                $display("FAIL sat_low: s=%h u=%h, required 80808080/00000000", out_q[1].d0, out_q[1].d1);
            else passed++;
            total++;
            if (out_q[2].d0 !== sc || out_q[2].d1 !== 32'hFF00FF00)
                $display("FAIL sat_mixed: s=%h u=%h, required %h/ff00ff00", out_q[2].d0, out_q[2].d1, sc);
            else passed++;
        end
        while (acc_q.size() > 0 && out_q.size() > 0) begin
            mb = acc_q.pop_front();
            mo = out_q.pop_front();
            e0 = ref_bus(mb, 1'b1);
            e1 = ref_bus(mb, 1'b0);
            el = (mb.idx % NFV) == NFV - 1;
            total++;
            if (mo.d0 !== e0 || mo.d1 !== e1 || mo.l0 !== el || mo.l1 !== el) begin
                $display("FAIL sat_beat%0d: s=%h u=%h last=%b/%b, required s=%h u=%h last=%b",
                         mb.idx, mo.d0, mo.d1, mo.l0, mo.l1, e0, e1, el);
            end else passed++;
        end
        acc_q.delete();
        out_q.delete();
    endtask

    task automatic test_rounding();
        int va[4];
        int vb[4];
        logic [31:0] es, eu;
`ifdef VVU_REQUANT_ROUND_EN
        es = 32'hFF02FF02;
        eu = 32'h00020002;
`else
        es = 32'hFE01FE01;
        eu = 32'h00010001;
`endif
        m_r = 1'b1;
        va = '{24, -24, 24, -24};
        vb = '{0, 0, 0, 0};
        push(va, vb);
        drain();
        total++;
        if (out_q.size() !== 1) $display("FAIL round_count: outputs=%0d required 1", out_q.size());
        else passed++;
        if (out_q.size() >= 1) begin
            total++;
            if (out_q[0].d0 !== es || out_q[0].d1 !== eu)
                $display("FAIL round_value: s=%h u=%h, required %h/%h", out_q[0].d0, out_q[0].d1, es, eu);
            else passed++;
        end
        acc_q.delete();
        out_q.delete();
    endtask

    task automatic test_backpressure();
        int start;
        int n;
        beat_t mb;
        obs_t mo;
        logic [31:0] e0, e1;
        logic el;
        m_r = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data[k*20 +: 20]   = 20'(rand_val());
            bias_data[k*20 +: 20] = 20'(rand_val());
        end
        in_v = 1'b1;
        b_v = 1'b1;
        start = acc_count;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (acc_count - start !== 2) $display("FAIL capacity: accepted=%0d while stalled, required 2", acc_count - start);
        else passed++;
        total++;
        if (in_r !== 1'b0 || b_r !== 1'b0) $display("FAIL capacity_ready: input=%b bias=%b, required 0/0", in_r, b_r);
        else passed++;
        start = acc_count;
        n = 0;
        while (acc_count - start < 500 && n < 20000) begin
            @(posedge clk); #1;
            n++;
            if (xfer) begin
                for (int k = 0; k < 4; k++) begin
                    in_data[k*20 +: 20]   = 20'(rand_val());
                    bias_data[k*20 +: 20] = 20'(rand_val());
                end
                in_v = 1'($urandom_range(0, 1));
                b_v  = 1'($urandom_range(0, 1));
            end else begin
                if (!in_v) in_v = 1'($urandom_range(0, 1));
                if (!b_v)  b_v  = 1'($urandom_range(0, 1));
            end
            m_r = ($urandom_range(0, 99) < 70);
        end
        in_v = 1'b0;
        b_v = 1'b0;
        drain();
        total++;
        if (out_q.size() !== acc_q.size()) $display("FAIL bp_count: outputs=%0d required %0d", out_q.size(), acc_q.size());
        else passed++;
        while (acc_q.size() > 0 && out_q.size() > 0) begin
            mb = acc_q.pop_front();
            mo = out_q.pop_front();
            e0 = ref_bus(mb, 1'b1);
            e1 = ref_bus(mb, 1'b0);
            el = (mb.idx % NFV) == NFV - 1;
            total++;
            if (mo.d0 !== e0 || mo.d1 !== e1 || mo.l0 !== el || mo.l1 !== el) begin
                $display("FAIL bp_beat%0d: s=%h u=%h last=%b/%b, required s=%h u=%h last=%b",
                         mb.idx, mo.d0, mo.d1, mo.l0, mo.l1, e0, e1, el);
            end else passed++;
        end
        acc_q.delete();
        out_q.delete();
    endtask

    task automatic test_frame();
        int k;
        int lasts;
        bit at127, at255;
        beat_t mb;
        obs_t mo;
        logic [31:0] e0, e1;
        logic el;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        acc_q.delete();
        out_q.delete();
        beat_idx = 0;
        rst = 1'b0;
        m_r = 1'b1;
        repeat (256) push_rand();
        drain();
        total++;
        if (out_q.size() !== 256) $display("FAIL frame_count: outputs=%0d required 256", out_q.size());
        else passed++;
        k = 0;
        lasts = 0;
        at127 = 1'b0;
        at255 = 1'b0;
        while (acc_q.size() > 0 && out_q.size() > 0) begin
            mb = acc_q.pop_front();
            mo = out_q.pop_front();
            e0 = ref_bus(mb, 1'b1);
            e1 = ref_bus(mb, 1'b0);
            el = (mb.idx % NFV) == NFV - 1;
            if (mo.l0) begin
                lasts++;
                if (k == 127) at127 = 1'b1;
                if (k == 255) at255 = 1'b1;
            end
            total++;
            if (mo.d0 !== e0 || mo.d1 !== e1 || mo.l0 !== el || mo.l1 !== el) begin
                $display("FAIL frame_beat%0d: s=%h u=%h last=%b/%b, required s=%h u=%h last=%b",
                         k, mo.d0, mo.d1, mo.l0, mo.l1, e0, e1, el);
            end else passed++;
            k++;
        end
        total++;
        if (lasts !== 2 || !at127 || !at255)
            $display("FAIL frame_tlast: count=%0d on127=%b on255=%b, required 2/1/1", lasts, at127, at255);
        else passed++;
        acc_q.delete();
        out_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        int k;
        int first_last;
        int lasts;
        beat_t mb;
        obs_t mo;
        logic [31:0] e0, e1;
        logic el;
        m_r = 1'b1;
        repeat (50) push_rand();
        rst = 1'b1;
        in_v = 1'b1;
        b_v = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (ov0 !== 1'b0 || in_r !== 1'b0 || b_r !== 1'b0)
                $display("FAIL midrst_quiet: valid=%b input_rdy=%b bias_rdy=%b, required 0/0/0", ov0, in_r, b_r);
            else passed++;
        end
        total++;
        if (out_q.size() !== 48) $display("FAIL midrst_before: outputs=%0d required 48", out_q.size());
        else passed++;
        while (acc_q.size() > 0 && out_q.size() > 0) begin
            mb = acc_q.pop_front();
            mo = out_q.pop_front();
            e0 = ref_bus(mb, 1'b1);
            e1 = ref_bus(mb, 1'b0);
            el = (mb.idx % NFV) == NFV - 1;
            total++;
            if (mo.d0 !== e0 || mo.d1 !== e1 || mo.l0 !== el || mo.l1 !== el) begin
                $display("FAIL midrst_pre_beat%0d: s=%h u=%h last=%b/%b, required s=%h u=%h last=%b",
                         mb.idx, mo.d0, mo.d1, mo.l0, mo.l1, e0, e1, el);
            end else passed++;
        end
        acc_q.delete();
        out_q.delete();
        beat_idx = 0;
        @(posedge clk); #1;
        in_v = 1'b0;
        b_v = 1'b0;
        rst = 1'b0;
        repeat (128) push_rand();
        drain();
        total++;
        if (out_q.size() !== 128) $display("FAIL midrst_after: outputs=%0d required 128", out_q.size());
        else passed++;
        k = 0;
        first_last = -1;
        lasts = 0;
        while (acc_q.size() > 0 && out_q.size() > 0) begin
            mb = acc_q.pop_front();
            mo = out_q.pop_front();
            e0 = ref_bus(mb, 1'b1);
            e1 = ref_bus(mb, 1'b0);
            el = (mb.idx % NFV) == NFV - 1;
            if (mo.l0) begin
                lasts++;
                if (first_last < 0) first_last = k;
            end
            total++;
            if (mo.d0 !== e0 || mo.d1 !== e1 || mo.l0 !== el || mo.l1 !== el) begin
                $display("FAIL midrst_post_beat%0d: s=%h u=%h last=%b/%b, required s=%h u=%h last=%b",
                         k, mo.d0, mo.d1, mo.l0, mo.l1, e0, e1, el);
            end else passed++;
            k++;
        end
        total++;
        if (first_last !== 127 || lasts !== 1)
            $display("FAIL midrst_tlast: first at beat %0d count=%0d, required beat 127 count 1", first_last, lasts);
        else passed++;
        acc_q.delete();
        out_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_frame();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
